// File: rtl/div_arb_if.sv
// ---------------------------------------------------------------------------
// div_arb_if -- handshake bundle between the clock-divider requesters and
// the div_arbiter.
//
// Signals:
//   req      [3:0]   per-requester level request, held for the whole use
//   mc_in    [67:0]  four packed 17-bit divider counts, requester i in
//                    mc_in[17*i+16:17*i]
//   grant    [3:0]   one-hot ownership, all zero when nobody owns the divider
//   owner    [1:0]   index of the current or most recent owner
//   busy             high while a requester owns the divider or during the
//                    post-release gap
//   maxcount [16:0]  count driven to the shared divider (0 = output held low)
//
// Modports:
//   master -- requester side (drives req/mc_in)
//   slave  -- arbiter side (drives grant/owner/busy/maxcount)
// ---------------------------------------------------------------------------
interface div_arb_if;
  logic [3:0]  req;
  logic [67:0] mc_in;
  logic [3:0]  grant;
  logic [1:0]  owner;
  logic        busy;
  logic [16:0] maxcount;

  modport master (
    output req, mc_in,
    input  grant, owner, busy, maxcount
  );

  modport slave (
    input  req, mc_in,
    output grant, owner, busy, maxcount
  );
endinterface

// File: rtl/div_arbiter.sv
// ---------------------------------------------------------------------------
// div_arbiter -- round-robin owner selection for a single shared clock
// divider. One of four requesters owns the divider at a time and its 17-bit
// count is forwarded (registered) to the divider. Every handover passes
// through a GAP of GAP_CYCLES cycles with maxcount forced to 0, so the
// divider output never jumps directly from one owner's count to another's.
//
// Ports:
//   clk    system clock, all state changes on its rising edge
//   rst_n  asynchronous active-low reset
//   bus    div_arb_if.slave (req, mc_in in; grant, owner, busy, maxcount out)
//
// Parameters:
//   GAP_CYCLES  idle cycles between owners, 1..255
//   MAX_TENURE  grant cycles before preemption, 2..65535 (only used when
//               DIV_ARB_TIMEOUT_EN is defined)
//
// Optional feature:
//   `define DIV_ARB_TIMEOUT_EN to preempt an owner that has held the divider
//   for MAX_TENURE cycles while another requester is waiting.
// ---------------------------------------------------------------------------
module div_arbiter #(
  parameter int GAP_CYCLES = 4,
  parameter int MAX_TENURE = 1024
) (
  input logic      clk,
  input logic      rst_n,
  div_arb_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Gap counter is loaded with GAP_CYCLES-1 and counts down to 0, so the
  // GAP state spans exactly GAP_CYCLES cycles.
  localparam logic [7:0] GapLoad = 8'(GAP_CYCLES - 1);

  state_t      state_q;
  logic [3:0]  grant_q;
  logic [1:0]  owner_q;
  logic        busy_q;
  logic [16:0] maxcount_q;
  logic [7:0]  gap_cnt_q;

  // Unpacked view of the four count slices.
  logic [16:0] mc_slice [4];

  for (genvar gi = 0; gi < 4; gi++) begin : g_slice
    assign mc_slice[gi] = bus.mc_in[17*gi +: 17];
  end

  // Round-robin pick: search owner+1, owner+2, owner+3, then owner itself.
  // The loop walks from the farthest candidate to the nearest so the last
  // hit (highest priority) wins.
  logic [1:0] pick_d;
  logic       pick_valid_d;
  logic [1:0] cand_d;

  always_comb begin
    pick_d       = owner_q;
    pick_valid_d = 1'b0;
    cand_d       = owner_q;
    for (int k = 4; k >= 1; k--) begin
      cand_d = owner_q + 2'(k);
      if (bus.req[cand_d]) begin
        pick_d       = cand_d;
        pick_valid_d = 1'b1;
      end
    end
  end

  // Owner gives up the divider when its request drops, or (optionally)
  // when its tenure has run out and someone else is waiting.
  logic leave_d;

`ifdef DIV_ARB_TIMEOUT_EN
  localparam logic [15:0] TenureLast = 16'(MAX_TENURE - 1);

  logic [15:0] tenure_q;
  logic        others_d;

  // grant_q is one-hot on the owner while in GRANT, so masking with it
  // leaves only competing requests.
  assign others_d = |(bus.req & ~grant_q);
  assign leave_d  = !bus.req[owner_q] || ((tenure_q == TenureLast) && others_d);
`else
  assign leave_d  = !bus.req[owner_q];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      grant_q    <= 4'b0000;
      owner_q    <= 2'd3;
      busy_q     <= 1'b0;
      maxcount_q <= 17'd0;
      gap_cnt_q  <= 8'd0;
`ifdef DIV_ARB_TIMEOUT_EN
      tenure_q   <= 16'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_valid_d) begin
            state_q    <= GRANT;
            owner_q    <= pick_d;
            grant_q    <= 4'b0001 << pick_d;
            maxcount_q <= mc_slice[pick_d];
            busy_q     <= 1'b1;
`ifdef DIV_ARB_TIMEOUT_EN
            tenure_q   <= 16'd0;
`endif
          end
        end

        GRANT: begin
          if (leave_d) begin
            state_q    <= GAP;
            grant_q    <= 4'b0000;
            maxcount_q <= 17'd0;
            gap_cnt_q  <= GapLoad;
          end else begin
            // Live count follows the owner's slice with one cycle delay;
            // a zero count is forwarded like any other value.
            maxcount_q <= mc_slice[owner_q];
`ifdef DIV_ARB_TIMEOUT_EN
            if (tenure_q != TenureLast) begin
              tenure_q <= tenure_q + 16'd1;
            end
`endif
          end
        end

        GAP: begin
          if (gap_cnt_q == 8'd0) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q - 8'd1;
          end
        end

        default: begin
          state_q    <= IDLE;
          grant_q    <= 4'b0000;
          busy_q     <= 1'b0;
          maxcount_q <= 17'd0;
        end
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.owner    = owner_q;
  assign bus.busy     = busy_q;
  assign bus.maxcount = maxcount_q;

endmodule

// File: tb/tb_div_arbiter.sv
// ---------------------------------------------------------------------------
// tb_div_arbiter -- self-checking bench for div_arbiter. Directed steps for
// reset, first grant, rotation, live count change, asynchronous reset and
// tenure behaviour, followed by random request/count traffic compared every
// cycle against a behavioural owner/cooldown model.
// ---------------------------------------------------------------------------
module tb_div_arbiter;

  localparam int GAP = 4;
  localparam int MT  = 8;
`ifdef DIV_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;

  div_arb_if bus ();

  div_arbiter #(
    .GAP_CYCLES (GAP),
    .MAX_TENURE (MT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: 0 = nobody owns, 1 = owned, 2 = cooling down.
  int          m_phase;
  int          m_owner;
  int          m_cool;
  int          m_held;
  logic [16:0] m_max;

  function automatic logic [16:0] slice(int i);
    return bus.mc_in[17*i +: 17];
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_owner = 3;
    m_cool  = 0;
    m_held  = 0;
    m_max   = '0;
  endtask

  task automatic model_tick();
    int         start;
    int         idx;
    bit         found;
    logic [3:0] own_mask;
    bit         others;
    case (m_phase)
      0: begin
        found = 1'b0;
        start = m_owner;
        for (int k = 1; k <= 4; k++) begin
          idx = (start + k) % 4;
          if (!found && bus.req[idx]) begin
            found   = 1'b1;
            m_phase = 1;
            m_owner = idx;
            m_max   = slice(idx);
            m_held  = 1;
          end
        end
      end
      1: begin
        own_mask = 4'b0001 << m_owner;
        others   = (bus.req & ~own_mask) != 4'b0000;
        if (!bus.req[m_owner] || (TO_EN && m_held >= MT && others)) begin
          m_phase = 2;
          m_cool  = GAP;
        end else begin
          m_max = slice(m_owner);
          if (m_held < MT) m_held++;
        end
      end
      default: begin
        m_cool--;
        if (m_cool == 0) m_phase = 0;
      end
    endcase
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(string tag);
    logic [3:0]  e_grant;
    logic [16:0] e_max;
    e_grant = (m_phase == 1) ? (4'b0001 << m_owner) : 4'b0000;
    e_max   = (m_phase == 1) ? m_max : 17'd0;
    chk({tag, "_grant"}, 32'(bus.grant), 32'(e_grant));
    chk({tag, "_max"},   32'(bus.maxcount), 32'(e_max));
    chk({tag, "_busy"},  32'(bus.busy), 32'(m_phase != 0));
    chk({tag, "_owner"}, 32'(bus.owner), 32'(m_owner));
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge.
  task automatic step(string tag);
    @(posedge clk);
    if (rst_n) model_tick();
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic set_mc(int a, int b, int c, int d);
    bus.mc_in = {17'(d), 17'(c), 17'(b), 17'(a)};
  endtask

  task automatic do_reset(logic [3:0] req_after);
    @(negedge clk);
    rst_n   = 1'b0;
    bus.req = 4'b0000;
    model_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = req_after;
  endtask

  task automatic handover(logic [3:0] new_req, logic [3:0] exp_grant, int exp_max);
    bus.req = new_req;
    for (int c = 0; c < GAP; c++) begin
      step("gap");
      chk("gap_grant_zero", 32'(bus.grant), 32'd0);
      chk("gap_max_zero", 32'(bus.maxcount), 32'd0);
      chk("gap_busy", 32'(bus.busy), 32'd1);
    end
    step("idle");
    chk("idle_busy", 32'(bus.busy), 32'd0);
    step("handover");
    chk("handover_grant", 32'(bus.grant), 32'(exp_grant));
    chk("handover_max", 32'(bus.maxcount), 32'(exp_max));
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.req   = 4'b0000;
    bus.mc_in = '0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    check_model("reset");
    chk("reset_owner", 32'(bus.owner), 32'd3);

    // First grant after reset: requester 0 wins a full request
    set_mc(10, 20, 30, 40);
    bus.req = 4'b1111;
    rst_n   = 1'b1;
    step("first");
    chk("first_grant", 32'(bus.grant), 32'b0001);
    chk("first_max", 32'(bus.maxcount), 32'd10);
    chk("first_owner", 32'(bus.owner), 32'd0);

    // Rotation 1, 2, 3, 0 through GAP + IDLE
    handover(4'b1110, 4'b0010, 20);
    handover(4'b1100, 4'b0100, 30);
    handover(4'b1000, 4'b1000, 40);
    handover(4'b0001, 4'b0001, 10);

    // Live count change mid-grant
    set_mc(50, 20, 30, 40);
    step("live50");
    chk("live_max50", 32'(bus.maxcount), 32'd50);
    set_mc(100, 20, 30, 40);
    step("live100");
    chk("live_max100", 32'(bus.maxcount), 32'd100);
    chk("live_grant", 32'(bus.grant), 32'b0001);
    set_mc(0, 20, 30, 40);
    step("zero_count");
    chk("zero_count_grant", 32'(bus.grant), 32'b0001);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(bus.grant), 32'd0);
    chk("async_max", 32'(bus.maxcount), 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    chk("async_owner", 32'(bus.owner), 32'd3);
    model_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    bus.req = 4'b0100;
    step("post_reset");
    chk("post_reset_grant", 32'(bus.grant), 32'b0100);

    // Tenure with two competing requesters
    do_reset(4'b0011);
    for (int c = 0; c < MT; c++) begin
      step("tenure");
      chk("tenure_hold", 32'(bus.grant), 32'b0001);
    end
    step("tenure_end");
    chk("tenure_end_grant", 32'(bus.grant), TO_EN ? 32'd0 : 32'b0001);
    repeat (GAP + 1) step("tenure_after");
    chk("tenure_next_grant", 32'(bus.grant), TO_EN ? 32'b0010 : 32'b0001);
    repeat (30) step("tenure_run");

    // Single requester held: never preempted, counter must not wrap
    do_reset(4'b1000);
    repeat (300) step("single");
    chk("single_grant", 32'(bus.grant), 32'b1000);

    // Random traffic
    do_reset(4'b0000);
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req[$urandom_range(0, 3)] ^= 1'b1;
      if ($urandom_range(0, 2) == 0) begin
        for (int i = 0; i < 4; i++)
          bus.mc_in[17*i +: 17] = ($urandom_range(0, 7) == 0) ? 17'd0 : 17'($urandom);
      end
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter GAP_CYCLES, default 4: idle cycles (maxcount forced 0) between owners; legal range 1..255.
REQ-002 Parameter MAX_TENURE, default 1024: grant cycles before preemption when DIV_ARB_TIMEOUT_EN is defined; legal range 2..65535.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 req  input  4  per-requester request for the shared clock divider; level, held for the whole use.
REQ-006 mc_in  input  68  four packed 17-bit divider counts; requester i uses mc_in[17*i+16:17*i].
REQ-007 grant  output  4  one-hot ownership; all zero when no owner.
REQ-008 owner  output  2  index of current or last owner.
REQ-009 busy  output  1  high in GRANT or GAP.
REQ-010 maxcount  output  17  divider count driven to the shared clock divider; 0 holds divider output low.

Function
REQ-011 FSM states are IDLE, GRANT and GAP; reset state is IDLE.
REQ-012 In IDLE with req==0: stay in IDLE; grant=0, maxcount=0, busy=0.
REQ-013 In IDLE with any req bit set: select the first set bit in round-robin order starting at owner+1 mod 4, then enter GRANT next edge.
REQ-014 Latency: a request seen in IDLE gets grant one cycle later; maxcount equals that requester's mc_in in the same cycle.
REQ-015 In GRANT: maxcount is a registered copy of the owner's mc_in slice, refreshed every cycle; a live change reaches the output after 1 cycle.
REQ-016 An owner count of 0 passes through unchanged; the arbiter does not treat it as a release.
REQ-017 In GRANT with req[owner]==0: clear grant and force maxcount=0 on the next edge, then enter GAP.
REQ-018 GAP lasts exactly GAP_CYCLES cycles; grant=0, maxcount=0, busy=1; new requests are ignored until GAP ends.
REQ-019 On GAP expiry: enter IDLE, which arbitrates on its first cycle (REQ-013).
REQ-020 Other requesters' req changes during GRANT do not affect the owner or maxcount.
REQ-021 owner updates only on entry to GRANT; round-robin pointer = owner, so a just-released requester has lowest priority.
REQ-022 The gap counter is 8 bits and the tenure counter is 16 bits; neither wraps, and both saturate or reload on state entry.
REQ-023 grant and maxcount never change in the same cycle from one nonzero owner to another; every handover passes through GAP.

Reset
REQ-024 Asserting rst_n low, including mid-GRANT or mid-GAP, immediately forces state=IDLE, grant=0, maxcount=0, busy=0, owner=3 and counters=0 without waiting for clk.
REQ-025 After rst_n deasserts, the first active edge evaluates IDLE; requester 0 wins a full simultaneous request.

Configuration
REQ-026 Macro DIV_ARB_TIMEOUT_EN enables tenure preemption.
REQ-027 With DIV_ARB_TIMEOUT_EN defined: the tenure counter clears on GRANT entry and increments each GRANT cycle. When it reaches MAX_TENURE-1 while any other req bit is set, the block enters GAP exactly as on a release. With no competing request, the owner is held and the counter saturates.
REQ-028 Without DIV_ARB_TIMEOUT_EN: no tenure counter exists, and the owner holds grant until its req drops.

Verification
REQ-029 Reset, then req=4'b1111 with mc_in slices 10,20,30,40 -> grant=0001 and maxcount=10 one cycle later; owner=0.
REQ-030 Owner 0 drops req with others still high -> next cycle grant=0 and maxcount=0 for exactly 4 cycles, then grant=0010 and maxcount=20 after the IDLE cycle; rotation continues 2,3,0.
REQ-031 Owner changes its mc_in from 50 to 100 mid-grant -> maxcount=100 one cycle later, with no gap or grant change.
REQ-032 Pull rst_n low mid-GRANT between clock edges -> grant=0 and maxcount=0 before the next clk edge; after release, req=0100 -> grant=0100.
REQ-033 With DIV_ARB_TIMEOUT_EN, MAX_TENURE=8, req=0011 held -> owner 0 loses grant after 8 cycles, GAP 4 cycles, then grant=0010. Without the macro -> owner 0 holds indefinitely.
REQ-034 Single requester req=1000 held 100000 cycles with the macro defined -> grant stays 1000 and the tenure counter saturates without wrapping.
